// File: rtl/general_register_write_arbiter_pkg.sv
// Shared types and constants for the general-register write path.
// Register indices follow x86 encoding order; byte enables select lanes
// of a 32-bit register (lane 0 = AL/AX/EAX low byte, lane 1 = AH).
package general_register_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] EAX = 3'd0;
   localparam logic [2:0] ECX = 3'd1;
   localparam logic [2:0] EDX = 3'd2;
   localparam logic [2:0] EBX = 3'd3;
   localparam logic [2:0] ESP = 3'd4;
   localparam logic [2:0] EBP = 3'd5;
   localparam logic [2:0] ESI = 3'd6;
   localparam logic [2:0] EDI = 3'd7;

   localparam logic [3:0] BE_LOW8  = 4'b0001;
   localparam logic [3:0] BE_HIGH8 = 4'b0010;
   localparam logic [3:0] BE_16    = 4'b0011;
   localparam logic [3:0] BE_32    = 4'b1111;

   typedef struct packed {
      logic [2:0]        index;
      logic [3:0]        byte_enable;
      logic [DATA_W-1:0] data;
      logic              illegal;
   } gr_write_t;

endpackage

// File: rtl/general_register_write_arbiter_if.sv
// Bundle between the two writeback requesters, the arbiter and the register file.
// No latency of its own; slave = arbiter view, master = requester/register-file view.
// Backpressure: req_ready per requester, wr_ready from the register file.
interface general_register_write_arbiter_if #(
   parameter int DATA_WIDTH = 32
);
   logic [1:0]                 req_valid;
   logic [1:0]                 req_ready;
   logic [1:0]                 req_lock;
   logic [1:0][2:0]            req_reg;
   logic [1:0]                 req_w_is_present;
   logic [1:0]                 req_w;
   logic [1:0]                 req_bit_width_16;
   logic [1:0]                 req_bit_width_32;
   logic [1:0][DATA_WIDTH-1:0] req_data;
   logic                       wr_valid;
   logic                       wr_ready;
   logic [2:0]                 wr_index;
   logic [3:0]                 wr_byte_enable;
   logic [DATA_WIDTH-1:0]      wr_data;
   logic                       wr_source;
   logic                       width_error;

   modport slave (
      input  req_valid, req_lock, req_reg, req_w_is_present, req_w,
             req_bit_width_16, req_bit_width_32, req_data, wr_ready,
      output req_ready, wr_valid, wr_index, wr_byte_enable, wr_data,
             wr_source, width_error
   );

   modport master (
      output req_valid, req_lock, req_reg, req_w_is_present, req_w,
             req_bit_width_16, req_bit_width_32, req_data, wr_ready,
      input  req_ready, wr_valid, wr_index, wr_byte_enable, wr_data,
             wr_source, width_error
   );
endinterface

// File: rtl/general_register_write_arbiter_format.sv
// Maps x86 reg field / w bit / operand width onto physical index, lanes, aligned data.
// Purely combinational, zero latency.
// No backpressure; illegal width combinations are flagged, not blocked.
module general_register_write_format
   import general_register_pkg::*;
(
   input  logic [2:0]        reg_i,
   input  logic              w_is_present_i,
   input  logic              w_i,
   input  logic              bit_width_16_i,
   input  logic              bit_width_32_i,
   input  logic [DATA_W-1:0] data_i,
   output gr_write_t         fmt_o
);

   // Byte ops address AL..BL in lane 0 and AH..BH in lane 1 of regs 0-3.
   always_comb begin
      fmt_o = '0;
      fmt_o.index = reg_i;
      if (w_is_present_i && !w_i) begin
         if (!reg_i[2]) begin
            fmt_o.byte_enable = BE_LOW8;
            fmt_o.data        = {24'd0, data_i[7:0]};
         end else begin
            fmt_o.index       = {1'b0, reg_i[1:0]};
            fmt_o.byte_enable = BE_HIGH8;
            fmt_o.data        = {16'd0, data_i[7:0], 8'd0};
         end
      end else if (bit_width_16_i && !bit_width_32_i) begin
         fmt_o.byte_enable = BE_16;
         fmt_o.data        = {16'd0, data_i[15:0]};
      end else if (bit_width_32_i && !bit_width_16_i) begin
         fmt_o.byte_enable = BE_32;
         fmt_o.data        = data_i;
      end else begin
         fmt_o.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/general_register_write_arbiter.sv
// Round-robin, lockable arbiter sharing the register-file write port between two writebacks.
// Latency: accept in cycle N -> wr_valid in N+1; full throughput of one write per cycle.
// Backpressure: req_ready only when the output register frees; held stable while wr_ready=0.
module general_register_write_arbiter
   import general_register_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clock,
   input  logic                             reset_n,
   general_register_write_arbiter_if.slave  bus
);

   gr_write_t             fmt_w [2];
   gr_write_t             sel_w;
   logic                  gnt;
   logic                  gnt_any;
   logic                  free;
   logic                  accept;
   logic [1:0]            ready;

   logic                  wr_valid_q, wr_valid_d;
   logic [2:0]            wr_index_q, wr_index_d;
   logic [3:0]            wr_be_q, wr_be_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  wr_source_q, wr_source_d;
   logic                  width_error_q, width_error_d;
   logic                  last_grant_q, last_grant_d;
   logic                  lock_vld_q, lock_vld_d;
   logic                  lock_owner_q, lock_owner_d;

   for (genvar i = 0; i < 2; i++) begin : g_fmt
      general_register_write_format u_fmt (
         .reg_i          (bus.req_reg[i]),
         .w_is_present_i (bus.req_w_is_present[i]),
         .w_i            (bus.req_w[i]),
         .bit_width_16_i (bus.req_bit_width_16[i]),
         .bit_width_32_i (bus.req_bit_width_32[i]),
         .data_i         (bus.req_data[i]),
         .fmt_o          (fmt_w[i])
      );
   end

   // Grant: a held lock pins the owner even while it idles; otherwise round-robin.
   always_comb begin
      gnt     = 1'b0;
      gnt_any = 1'b0;
      if (lock_vld_q) begin
         gnt     = lock_owner_q;
         gnt_any = 1'b1;
      end else begin
         case (bus.req_valid)
            2'b01:   begin gnt = 1'b0;          gnt_any = 1'b1; end
            2'b10:   begin gnt = 1'b1;          gnt_any = 1'b1; end
            2'b11:   begin gnt = ~last_grant_q; gnt_any = 1'b1; end
            default: begin gnt = 1'b0;          gnt_any = 1'b0; end
         endcase
      end
   end

   assign free     = ~wr_valid_q | bus.wr_ready;
   assign ready[0] = free & gnt_any & ~gnt;
   assign ready[1] = free & gnt_any & gnt;
   assign accept   = |(ready & bus.req_valid);
   assign sel_w    = fmt_w[gnt];

   // Next state: drain on handshake, load on legal accept, flag illegal widths.
   always_comb begin
      wr_valid_d    = wr_valid_q;
      wr_index_d    = wr_index_q;
      wr_be_d       = wr_be_q;
      wr_data_d     = wr_data_q;
      wr_source_d   = wr_source_q;
      width_error_d = 1'b0;
      last_grant_d  = last_grant_q;
      lock_vld_d    = lock_vld_q;
      lock_owner_d  = lock_owner_q;
      if (wr_valid_q && bus.wr_ready) begin
         wr_valid_d = 1'b0;
      end
      if (accept) begin
         last_grant_d = gnt;
         lock_vld_d   = bus.req_lock[gnt];
         lock_owner_d = gnt;
         if (sel_w.illegal) begin
            width_error_d = 1'b1;
         end else begin
            wr_valid_d  = 1'b1;
            wr_index_d  = sel_w.index;
            wr_be_d     = sel_w.byte_enable;
            wr_data_d   = sel_w.data;
            wr_source_d = gnt;
         end
      end
   end

   // State registers; reset drops any pending write and any held lock.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_valid_q    <= 1'b0;
         wr_index_q    <= '0;
         wr_be_q       <= '0;
         wr_data_q     <= '0;
         wr_source_q   <= 1'b0;
         width_error_q <= 1'b0;
         last_grant_q  <= 1'b1;
         lock_vld_q    <= 1'b0;
         lock_owner_q  <= 1'b0;
      end else begin
         wr_valid_q    <= wr_valid_d;
         wr_index_q    <= wr_index_d;
         wr_be_q       <= wr_be_d;
         wr_data_q     <= wr_data_d;
         wr_source_q   <= wr_source_d;
         width_error_q <= width_error_d;
         last_grant_q  <= last_grant_d;
         lock_vld_q    <= lock_vld_d;
         lock_owner_q  <= lock_owner_d;
      end
   end

   assign bus.req_ready      = ready;
   assign bus.wr_valid       = wr_valid_q;
   assign bus.wr_index       = wr_index_q;
   assign bus.wr_byte_enable = wr_be_q;
   assign bus.wr_data        = wr_data_q;
   assign bus.wr_source      = wr_source_q;
   assign bus.width_error    = width_error_q;

endmodule

// File: doc/general_register_write_arbiter.md
Name: general_register_write_arbiter

Overview:
- Shares the single general-register-file write port between two requesters: req 0 is execute writeback, req 1 is microcode/string-unit writeback.
- Round-robin arbitration with per-requester lock, for atomic multi-write sequences such as XCHG and POPA.
- Converts the x86 reg field, w bit and operand width into a physical register index, byte enables and lane-aligned data.
- Registered output stage with valid/ready toward the register file; sits between the execution back end and the register file.

Parameters:
- DATA_WIDTH, 32, width of write data.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester write request.
- req_ready  out  2  per-requester accept; handshake completes when valid & ready.
- req_lock  in  2  hold the grant on this requester while asserted.
- req_reg  in  2x3  reg field per requester.
- req_w_is_present  in  2  w bit is meaningful.
- req_w  in  2  w bit.
- req_bit_width_16  in  2  16-bit operand size.
- req_bit_width_32  in  2  32-bit operand size.
- req_data  in  2xDATA_WIDTH  unaligned result; byte results are in [7:0].
- wr_valid  out  1  register-file write valid.
- wr_ready  in  1  register file accepts the write.
- wr_index  out  3  physical register: 0=EAX, 1=ECX, 2=EDX, 3=EBX, 4=ESP, 5=EBP, 6=ESI, 7=EDI.
- wr_byte_enable  out  4  lane enables.
- wr_data  out  DATA_WIDTH  lane-aligned data.
- wr_source  out  1  requester that produced the current output.
- width_error  out  1  one-cycle pulse on an illegal width request.

Behaviour:
- Reset (async, reset_n=0):
  - wr_valid=0, wr_index=0, wr_byte_enable=0, wr_data=0, wr_source=0, width_error=0.
  - last_grant=1, so req 0 wins the first conflict.
  - lock_owner cleared.
- Reset asserted mid-transfer drops the pending output; no write is issued.
- Output register is free when wr_valid=0, or when wr_valid & wr_ready in the same cycle (full throughput, 1 write/cycle).
- Grant is combinational and computed each cycle:
  - If a lock is held, grant = lock_owner, and only that requester may see ready.
  - Else if only one requester is valid, that one is granted.
  - Else if both are valid, grant = ~last_grant.
- req_ready[g] = free & granted; the other requester's ready is 0.
- On accept:
  - the output register loads the formatted write;
  - last_grant <= g;
  - if req_lock[g]=1, lock_owner <= g (locked).
- Lock release: the lock clears on the first accepted request from the owner with req_lock=0, i.e. the final write of the sequence.
- While locked, the other requester stalls indefinitely; the owner may idle between writes without losing the lock.
- Latency: accept in cycle N -> wr_valid=1 in cycle N+1. Output holds stable while wr_valid & ~wr_ready.
- Formatting, 8-bit case (w_is_present=1 & w=0):
  - reg 0-3: index=reg, be=0001, data[7:0]=req_data[7:0].
  - reg 4-7: index=reg-4, be=0010, data[15:8]=req_data[7:0].
  - All other bytes are 0.
- Formatting, full-width case (w_is_present=0, or w=1):
  - 16-bit only: index=reg, be=0011, data[15:0].
  - 32-bit only: index=reg, be=1111, data[31:0].
- Illegal full-width request (bit_width_16 == bit_width_32, both 0 or both 1):
  - the request is still accepted so the requester does not hang;
  - the output register is not loaded, so wr_valid stays as it was;
  - width_error pulses 1 in cycle N+1;
  - last_grant and lock state update as for a legal accept.
- Width bits are ignored in the 8-bit case.
- Unused data lanes are always driven 0.

Decomposition:
- Package general_register_pkg:
  - register index constants EAX..EDI;
  - byte-enable constants BE_LOW8=0001, BE_HIGH8=0010, BE_16=0011, BE_32=1111;
  - a formatted-write struct {index, byte_enable, data, illegal}.
- Sub-module general_register_write_format: purely combinational reg/w/width -> formatted-write struct. One instance per requester, muxed by grant.

Test Plan:
- Single req 0, reg=4, w_is_present=1, w=0, data=0xA5 -> next cycle wr_index=0, be=0010, wr_data=0x0000A500, wr_source=0.
- Both valid every cycle with wr_ready=1, 32-bit, reg=1 for req 0 and reg=6 for req 1 -> writes alternate sources 0,1,0,1 starting with 0, one per cycle, indices 1,6,1,6.
- Req 1 issues three writes with lock=1,1,0 while req 0 is continuously valid -> req 0 sees ready=0 until the third req 1 write is accepted, then req 0 is granted next.
- wr_ready=0 for 3 cycles with both requesters valid -> wr_valid held, output stable, req_ready=00; wr_ready rises -> the held write completes and the next grant is accepted in the same cycle.
- Req 0 full width with bit_width_16=1 and bit_width_32=1 -> req_ready=1, width_error=1 for one cycle, no wr_valid; then 16-bit reg=3, data=0x12345678 -> index=3, be=0011, wr_data=0x00005678.
- reset_n pulsed low asynchronously mid-clock while wr_valid=1 and req 1 is locked -> all outputs 0 immediately, lock cleared, first post-reset conflict is granted to req 0.
